// File: rtl/vp_pkg.sv
// Shared types and default parameters for the load value speculation controller.
package vp_pkg;

  localparam int VP_INDEX_WIDTH = 6;
  localparam int VP_CONF_BITS   = 2;
  localparam int VP_CONF_THRESH = 2;
  localparam int VP_MAX_WAIT    = 64;
  localparam int VP_STAT_WIDTH  = 16;
  localparam int VP_ADDR_WIDTH  = 32;
  localparam int VP_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {IDLE, SPEC, WAIT, RECOVER} vp_state_t;
  typedef logic [VP_CONF_BITS-1:0] vp_conf_t;

endpackage

// File: rtl/vp_conf_table.sv
// Per-PC saturating confidence counters: one combinational read, one inc/clear write.
module vp_conf_table #(
  parameter int INDEX_WIDTH = 6,
  parameter int CONF_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic [CONF_BITS-1:0]   rd_conf,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic                   wr_inc
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [CONF_BITS-1:0] conf_flat [ENTRIES];

  // Each entry is its own register so the whole table clears on reset.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic [CONF_BITS-1:0] cnt_reg;

    // Increment saturates at all-ones; a clear write returns the entry to zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (wr_en && (wr_idx == INDEX_WIDTH'(gi))) begin
        if (!wr_inc)
          cnt_reg <= '0;
        else if (cnt_reg != '1)
          cnt_reg <= cnt_reg + CONF_BITS'(1);
      end
    end

    assign conf_flat[gi] = cnt_reg;
  end

  // Lookup reads the registered value, so a same-cycle write is not visible yet.
  assign rd_conf = conf_flat[rd_idx];

endmodule

// File: rtl/vp_spec_ctrl.sv
// MEM-stage load value speculation sequencer: predict-or-stall on a miss,
// verify the fill, train the confidence table, and drive recovery.
module vp_spec_ctrl
  import vp_pkg::*;
#(
  parameter int INDEX_WIDTH = VP_INDEX_WIDTH,
  parameter int CONF_BITS   = VP_CONF_BITS,
  parameter int CONF_THRESH = VP_CONF_THRESH,
  parameter int MAX_WAIT    = VP_MAX_WAIT,
  parameter int STAT_WIDTH  = VP_STAT_WIDTH,
  parameter int ADDR_WIDTH  = VP_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VP_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_miss_valid,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  input  logic [DATA_WIDTH-1:0] pred_data,
  input  logic                  cache_rsp_valid,
  input  logic [DATA_WIDTH-1:0] cache_rsp_data,
  input  logic                  recovery_done,
  output logic                  vp_use,
  output logic [DATA_WIDTH-1:0] vp_value,
  output logic                  stall_req,
  output logic                  recover,
  output logic [ADDR_WIDTH-1:0] recover_pc,
  output logic                  commit,
  output logic                  timeout_err,
  output logic [STAT_WIDTH-1:0] pred_count,
  output logic [STAT_WIDTH-1:0] mispred_count
);

  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  vp_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] val_reg, val_next;
  logic [ADDR_WIDTH-1:0] recover_pc_reg, recover_pc_next;
  logic [WAIT_W-1:0]     wait_reg, wait_next;
  logic                  vp_use_reg, vp_use_next;
  logic                  commit_reg, commit_next;
  logic                  recover_reg, recover_next;
  logic                  timeout_reg, timeout_next;
  logic [STAT_WIDTH-1:0] pred_cnt_reg, pred_cnt_next;
  logic [STAT_WIDTH-1:0] mispred_cnt_reg, mispred_cnt_next;

  logic [CONF_BITS-1:0]   rd_conf;
  logic                   tbl_wr_en;
  logic                   tbl_wr_inc;
  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [INDEX_WIDTH-1:0] wr_idx;

  // Lookup uses the incoming miss PC; training always targets the captured PC.
  assign rd_idx = load_pc[INDEX_WIDTH+1:2];
  assign wr_idx = pc_reg[INDEX_WIDTH+1:2];

  vp_conf_table #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .CONF_BITS   (CONF_BITS)
  ) u_conf_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (rd_idx),
    .rd_conf (rd_conf),
    .wr_en   (tbl_wr_en),
    .wr_idx  (wr_idx),
    .wr_inc  (tbl_wr_inc)
  );

  // State and datapath registers; pulses are registered so they last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      val_reg         <= '0;
      recover_pc_reg  <= '0;
      wait_reg        <= '0;
      vp_use_reg      <= 1'b0;
      commit_reg      <= 1'b0;
      recover_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
      pred_cnt_reg    <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      val_reg         <= val_next;
      recover_pc_reg  <= recover_pc_next;
      wait_reg        <= wait_next;
      vp_use_reg      <= vp_use_next;
      commit_reg      <= commit_next;
      recover_reg     <= recover_next;
      timeout_reg     <= timeout_next;
      pred_cnt_reg    <= pred_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  // Next-state, training and stall decisions for the single outstanding speculation.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    val_next         = val_reg;
    recover_pc_next  = recover_pc_reg;
    wait_next        = wait_reg;
    vp_use_next      = 1'b0;
    commit_next      = 1'b0;
    recover_next     = 1'b0;
    timeout_next     = timeout_reg;
    pred_cnt_next    = pred_cnt_reg;
    mispred_cnt_next = mispred_cnt_reg;
    tbl_wr_en        = 1'b0;
    tbl_wr_inc       = 1'b0;
    stall_req        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_miss_valid) begin
          pc_next   = load_pc;
          val_next  = pred_data;
          wait_next = '0;
          if (int'(rd_conf) >= CONF_THRESH) begin
            vp_use_next = 1'b1;
            if (pred_cnt_reg != '1)
              pred_cnt_next = pred_cnt_reg + STAT_WIDTH'(1);
            state_next = SPEC;
          end else begin
            state_next = WAIT;
          end
        end
      end

      SPEC: begin
        // Hold off a younger miss while the predicted load is still unverified.
        stall_req = load_miss_valid;
        if (cache_rsp_valid || (wait_reg == WAIT_LAST)) begin
          tbl_wr_en = 1'b1;
          if (cache_rsp_valid && (cache_rsp_data == val_reg)) begin
            tbl_wr_inc  = 1'b1;
            commit_next = 1'b1;
            state_next  = IDLE;
          end else begin
            // Wrong value, or no fill in time: both squash and reset confidence.
            tbl_wr_inc      = 1'b0;
            recover_next    = 1'b1;
            recover_pc_next = pc_reg;
            if (mispred_cnt_reg != '1)
              mispred_cnt_next = mispred_cnt_reg + STAT_WIDTH'(1);
            if (!cache_rsp_valid)
              timeout_next = 1'b1;
            state_next = RECOVER;
          end
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      WAIT: begin
        stall_req = 1'b1;
        if (cache_rsp_valid) begin
          tbl_wr_en  = 1'b1;
          tbl_wr_inc = (cache_rsp_data == val_reg);
          state_next = IDLE;
        end else if (wait_reg == WAIT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      RECOVER: begin
        stall_req = 1'b1;
        if (recovery_done)
          state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign vp_use        = vp_use_reg;
  assign vp_value      = val_reg;
  assign commit        = commit_reg;
  assign recover       = recover_reg;
  assign recover_pc    = recover_pc_reg;
  assign timeout_err   = timeout_reg;
  assign pred_count    = pred_cnt_reg;
  assign mispred_count = mispred_cnt_reg;

endmodule

// File: tb/tb_vp_spec_ctrl.sv
// Scoreboard bench for vp_spec_ctrl with a transaction-level reference model.
module tb_vp_spec_ctrl;
  import vp_pkg::*;

  localparam int MW  = VP_MAX_WAIT;
  localparam int NTX = 150;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_miss_valid = 1'b0;
  logic [31:0] load_pc = '0;
  logic [31:0] pred_data = '0;
  logic        cache_rsp_valid = 1'b0;
  logic [31:0] cache_rsp_data = '0;
  logic        recovery_done = 1'b0;
  logic        vp_use;
  logic [31:0] vp_value;
  logic        stall_req;
  logic        recover;
  logic [31:0] recover_pc;
  logic        commit;
  logic        timeout_err;
  logic [15:0] pred_count;
  logic [15:0] mispred_count;

  vp_spec_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_miss_valid (load_miss_valid),
    .load_pc         (load_pc),
    .pred_data       (pred_data),
    .cache_rsp_valid (cache_rsp_valid),
    .cache_rsp_data  (cache_rsp_data),
    .recovery_done   (recovery_done),
    .vp_use          (vp_use),
    .vp_value        (vp_value),
    .stall_req       (stall_req),
    .recover         (recover),
    .recover_pc      (recover_pc),
    .commit          (commit),
    .timeout_err     (timeout_err),
    .pred_count      (pred_count),
    .mispred_count   (mispred_count)
  );

  always #5 clk = ~clk;

  // Event kinds as {vp_use, commit, recover}.
  localparam logic [2:0] EV_USE = 3'b100;
  localparam logic [2:0] EV_COMMIT = 3'b010;
  localparam logic [2:0] EV_RECOVER = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state.
  int   m_conf [64];
  int   m_pred;
  int   m_mispred;
  bit   m_timeout;
  bit   exp_stall;
  int   cyc;
  int   n_checks;
  int   n_fail;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_conf[i] = 0;
    m_pred = 0;
    m_mispred = 0;
    m_timeout = 0;
    exp_stall = 0;
    exp_q.delete();
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Cycle counter: value seen by the monitor names the cycle just after an edge.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: compares outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk(stall_req == exp_stall, "stall_req", 64'(stall_req), 64'(exp_stall));
      chk(pred_count == 16'(m_pred), "pred_count", 64'(pred_count), 64'(m_pred));
      chk(mispred_count == 16'(m_mispred), "mispred_count", 64'(mispred_count), 64'(m_mispred));
      chk(timeout_err == m_timeout, "timeout_err", 64'(timeout_err), 64'(m_timeout));
      if (vp_use || commit || recover) begin
        chk($countones({vp_use, commit, recover}) == 1, "pulse_exclusive",
            64'({vp_use, commit, recover}), 64'(0));
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", 64'({vp_use, commit, recover}), 64'(0));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk({vp_use, commit, recover} == e.kind, "pulse_kind",
              64'({vp_use, commit, recover}), 64'(e.kind));
          chk(cyc == e.cyc, "pulse_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind == EV_USE)
            chk(vp_value == e.data, "vp_value", 64'(vp_value), 64'(e.data));
          if (e.kind == EV_RECOVER)
            chk(recover_pc == e.data, "recover_pc", 64'(recover_pc), 64'(e.data));
        end
      end
    end
  end

  // Squash handshake: pipeline reports recovery_done after a random delay.
  task automatic do_recovery();
    int r;
    r = $urandom_range(0, 3);
    for (int j = 0; j <= r; j++) begin
      exp_stall = 1;
      recovery_done = (j == r);
      @(posedge clk); #1;
      recovery_done = 1'b0;
    end
    exp_stall = 0;
  endtask

  // Idle cycles carrying stray fills and recovery_done that must be ignored.
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      exp_stall = 0;
      cache_rsp_valid = ($urandom_range(0, 3) == 0);
      cache_rsp_data  = $urandom;
      recovery_done   = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      cache_rsp_valid = 1'b0;
      recovery_done   = 1'b0;
    end
  endtask

  // One load miss. rsp_k: cycle after acceptance carrying the fill (-1 = never).
  // extra_k: cycle with a second miss; rst_k: cycle at which reset is asserted.
  task automatic txn(input logic [31:0] pc, input logic [31:0] pred, input int rsp_k,
                     input logic [31:0] rsp, input int extra_k, input int rst_k);
    int  idx;
    bit  predict;
    bit  done;
    int  k;
    idx = int'(pc[7:2]);
    @(posedge clk); #1;
    exp_stall = 0;
    load_miss_valid = 1'b1;
    load_pc = pc;
    pred_data = pred;
    predict = (m_conf[idx] >= VP_CONF_THRESH);
    @(posedge clk); #1;
    load_miss_valid = 1'b0;
    load_pc = $urandom;
    pred_data = $urandom;
    if (predict) begin
      push_ev(EV_USE, pred);
      if (m_pred < 65535) m_pred++;
    end
    k = 0;
    done = 0;
    while (!done) begin
      exp_stall = !predict;
      cache_rsp_valid = (k == rsp_k);
      cache_rsp_data  = (k == rsp_k) ? rsp : 32'($urandom);
      recovery_done   = ($urandom_range(0, 4) == 0);
      if (k == extra_k) begin
        load_miss_valid = 1'b1;
        load_pc = $urandom;
        pred_data = $urandom;
        exp_stall = 1;
      end
      if (k == rst_k) begin
        rst_n = 1'b0;
        load_miss_valid = 1'b0;
        cache_rsp_valid = 1'b0;
        recovery_done = 1'b0;
        #1;
        chk({vp_use, commit, recover, stall_req, timeout_err} == 5'b0 &&
            vp_value == 0 && recover_pc == 0 && pred_count == 0 && mispred_count == 0,
            "reset_mid_op", 64'({vp_use, commit, recover, stall_req, timeout_err}), 64'(0));
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cache_rsp_valid = 1'b0;
      load_miss_valid = 1'b0;
      recovery_done   = 1'b0;
      if (k == rsp_k) begin
        done = 1;
        if (rsp == pred) begin
          if (m_conf[idx] < 3) m_conf[idx]++;
          if (predict) push_ev(EV_COMMIT, pred);
          exp_stall = 0;
        end else begin
          m_conf[idx] = 0;
          if (predict) begin
            if (m_mispred < 65535) m_mispred++;
            push_ev(EV_RECOVER, pc);
            do_recovery();
          end
          exp_stall = 0;
        end
      end else if (k == MW - 1) begin
        done = 1;
        m_timeout = 1;
        if (predict) begin
          m_conf[idx] = 0;
          if (m_mispred < 65535) m_mispred++;
          push_ev(EV_RECOVER, pc);
          do_recovery();
        end
        exp_stall = 0;
      end
      k++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs [4];
    logic [31:0] pc;
    logic [31:0] pr;
    logic [31:0] rs;
    int rk;
    int ek;
    int tk;
    n_checks = 0;
    n_fail = 0;
    model_clear();
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hC4; pcs[3] = 32'h1040;

    repeat (3) @(posedge clk);
    #1;
    chk({vp_use, commit, recover, stall_req, timeout_err} == 5'b0 &&
        vp_value == 0 && recover_pc == 0 && pred_count == 0 && mispred_count == 0,
        "reset_state", 64'({vp_use, commit, recover, stall_req, timeout_err}), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Cold misses train pc 0x40; the third one predicts and commits.
    txn(32'h40, 32'h0, 2, 32'h0, -1, -1);
    idle(1);
    txn(32'h40, 32'h0, 2, 32'h0, -1, -1);
    idle(1);
    txn(32'h40, 32'h0, 2, 32'h0, -1, -1);
    idle(2);
    // Trained pc with a wrong prediction.
    txn(32'h40, 32'h0, 1, 32'h1234, -1, -1);
    idle(2);
    // Retrain, then a speculation that never sees its fill.
    txn(32'h40, 32'h0, 0, 32'h0, -1, -1);
    txn(32'h40, 32'h0, 0, 32'h0, -1, -1);
    txn(32'h40, 32'h0, -1, 32'h0, -1, -1);
    idle(2);
    // Retrain, then a second miss arriving mid-speculation.
    txn(32'h40, 32'h0, 0, 32'h0, -1, -1);
    txn(32'h40, 32'h0, 0, 32'h0, -1, -1);
    txn(32'h40, 32'h0, 4, 32'h0, 1, -1);
    idle(2);
    // Reset during a speculation; the same pc must not predict afterwards.
    txn(32'h40, 32'h7, 5, 32'h7, -1, 2);
    idle(2);
    txn(32'h40, 32'h7, 1, 32'h7, -1, -1);
    idle(2);
    // A WAIT that times out.
    txn(32'h80, 32'h9, -1, 32'h9, -1, -1);
    idle(2);

    for (int t = 0; t < NTX; t++) begin
      pc = pcs[$urandom_range(0, 3)];
      case ($urandom_range(0, 2))
        0: pr = 32'h0;
        1: pr = 32'h55;
        default: pr = $urandom;
      endcase
      rs = ($urandom_range(0, 3) != 0) ? pr : (pr ^ 32'h1);
      rk = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 8));
      ek = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      tk = ($urandom_range(0, 59) == 0) ? int'($urandom_range(0, 3)) : -1;
      txn(pc, pr, rk, rs, ek, tk);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk(exp_q.size() == 0, "pending_events", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
